// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request at or above ptr, mod 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        idx = ptr;
        any = |req;
        // Scan from the farthest offset down so the nearest hit is assigned last.
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                idx = ptr + 2'(i);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter/sequencer for one shared bus port with up to four requesters
// and a response watchdog.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    localparam int CNT_W  = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_valid,
    output logic [3:0] req_ready,
    output logic [3:0] resp_valid,
    output logic       resp_err,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       m_resp_valid,
    output logic       busy
);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       timeout;
    logic       resp_fire;

    // In the response cycle the pointer has not been written yet, so feed sel+1 directly.
    assign pick_ptr = (state_q == WAIT) ? sel_q + 2'd1 : ptr_q;

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign timeout   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign resp_fire = (state_q == WAIT) && (m_resp_valid || timeout);

    assign sel        = sel_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);
    assign m_valid    = (state_q == ISSUE) && req_valid[sel_q];
    assign req_ready  = (m_valid && m_ready) ? onehot4(sel_q) : 4'b0000;
    assign resp_valid = resp_fire ? onehot4(sel_q) : 4'b0000;
    assign resp_err   = resp_fire && !m_resp_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    grant_d = onehot4(pick_idx);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!req_valid[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                end else if (m_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (resp_fire) begin
                    ptr_d = sel_q + 2'd1;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        grant_d = onehot4(pick_idx);
                        state_d = ISSUE;
                    end else begin
                        grant_d = 4'b0000;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
